// File: rtl/key_event_encoder_pkg.sv
// Shared definitions for the key event encoder: key codes, per-key
// vector indices (which double as the encode priority order) and the
// default debounce length.
package key_event_encoder_pkg;

   // 20 ms of stable input at a 1 MHz system clock
   localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;

   localparam int NUM_KEYS   = 5;
   localparam int KEY_CODE_W = 3;

   typedef enum logic [KEY_CODE_W-1:0] {
      KEY_NONE    = 3'd0,
      KEY_RESTART = 3'd1,
      KEY_UP      = 3'd2,
      KEY_DOWN    = 3'd3,
      KEY_LEFT    = 3'd4,
      KEY_RIGHT   = 3'd5
   } key_code_e;

   // Bit positions in the per-key vectors. Lower index means higher
   // priority when several presses land in the same cycle.
   localparam int KEY_IDX_RESTART = 0;
   localparam int KEY_IDX_UP      = 1;
   localparam int KEY_IDX_DOWN    = 2;
   localparam int KEY_IDX_LEFT    = 3;
   localparam int KEY_IDX_RIGHT   = 4;

   // Priority encode: RESTART > UP > DOWN > LEFT > RIGHT.
   function automatic key_code_e encode_press(input logic [NUM_KEYS-1:0] pulses);
      key_code_e code;
      if (pulses[KEY_IDX_RESTART])    code = KEY_RESTART;
      else if (pulses[KEY_IDX_UP])    code = KEY_UP;
      else if (pulses[KEY_IDX_DOWN])  code = KEY_DOWN;
      else if (pulses[KEY_IDX_LEFT])  code = KEY_LEFT;
      else if (pulses[KEY_IDX_RIGHT]) code = KEY_RIGHT;
      else                            code = KEY_NONE;
      return code;
   endfunction

   // True when two or more bits are set (clearing the lowest set bit
   // leaves something behind).
   function automatic logic more_than_one(input logic [NUM_KEYS-1:0] v);
      return |(v & (v - NUM_KEYS'(1)));
   endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Key event bundle: raw key levels toward the encoder, per-key press
// pulses and the encoded event back out.
interface key_event_if;
   import key_event_encoder_pkg::*;

   // raw, unsynchronized key levels (active high)
   logic KeyRESTART;
   logic Keyup;
   logic KeyDown;
   logic KeyLeft;
   logic KeyRight;

   // one-cycle press events
   logic restart_pulse;
   logic up_pulse;
   logic down_pulse;
   logic left_pulse;
   logic right_pulse;

   // encoded event
   logic                  key_valid;
   logic [KEY_CODE_W-1:0] key_code;
   logic                  key_drop;

   // keypad side: drives keys, observes events
   modport master (
      output KeyRESTART, Keyup, KeyDown, KeyLeft, KeyRight,
      input  restart_pulse, up_pulse, down_pulse, left_pulse, right_pulse,
      input  key_valid, key_code, key_drop
   );

   // encoder side
   modport slave (
      input  KeyRESTART, Keyup, KeyDown, KeyLeft, KeyRight,
      output restart_pulse, up_pulse, down_pulse, left_pulse, right_pulse,
      output key_valid, key_code, key_drop
   );
endinterface

// File: rtl/key_event_encoder_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce counter with a
// stable state, and a registered one-cycle pulse on a stable rising edge.
module key_debounce_ch
   import key_event_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_raw,
   output logic press_pulse
);

   // $clog2(N) bits hold N-1, the largest count we ever store
   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta_reg;
   logic             sync_reg;
   logic             stable_reg;
   logic             stable_next;
   logic             stable_d_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             pulse_reg;

   // Counter runs only while the synchronized level disagrees with the
   // stable state; any agreeing sample restarts the count from zero.
   always_comb begin
      stable_next = stable_reg;
      count_next  = count_reg;
      if (sync_reg == stable_reg) begin
         count_next = '0;
      end else if (count_reg == CNT_MAX) begin
         stable_next = sync_reg;
         count_next  = '0;
      end else begin
         count_next = count_reg + CNT_W'(1);
      end
   end

   // Synchronizer, debounce state and edge-detect pulse register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_meta_reg <= 1'b0;
         sync_reg      <= 1'b0;
         stable_reg    <= 1'b0;
         stable_d_reg  <= 1'b0;
         count_reg     <= '0;
         pulse_reg     <= 1'b0;
      end else begin
         sync_meta_reg <= key_raw;
         sync_reg      <= sync_meta_reg;
         stable_reg    <= stable_next;
         count_reg     <= count_next;
         stable_d_reg  <= stable_reg;
         // rising edge of the stable state only; releases are silent
         pulse_reg     <= stable_reg & ~stable_d_reg;
      end
   end

   assign press_pulse = pulse_reg;

endmodule

// File: rtl/key_event_encoder.sv
// Five independently debounced keys feeding a priority encoder. The
// per-key pulses are registered in the channels; the encoded strobe,
// code and drop flag are decoded from them so they line up exactly.
module key_event_encoder
   import key_event_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   key_event_if.slave    bus
);

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] press;
   key_code_e           code;
   logic                valid;
   logic                drop;

   assign key_raw[KEY_IDX_RESTART] = bus.KeyRESTART;
   assign key_raw[KEY_IDX_UP]      = bus.Keyup;
   assign key_raw[KEY_IDX_DOWN]    = bus.KeyDown;
   assign key_raw[KEY_IDX_LEFT]    = bus.KeyLeft;
   assign key_raw[KEY_IDX_RIGHT]   = bus.KeyRight;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
         key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .key_raw     (key_raw[gi]),
            .press_pulse (press[gi])
         );
      end
   endgenerate

   // Encode the highest-priority press; flag lost simultaneous presses.
   always_comb begin
      valid = |press;
      code  = encode_press(press);
      drop  = more_than_one(press);
   end

   assign bus.restart_pulse = press[KEY_IDX_RESTART];
   assign bus.up_pulse      = press[KEY_IDX_UP];
   assign bus.down_pulse    = press[KEY_IDX_DOWN];
   assign bus.left_pulse    = press[KEY_IDX_LEFT];
   assign bus.right_pulse   = press[KEY_IDX_RIGHT];
   assign bus.key_valid     = valid;
   assign bus.key_code      = code;
   assign bus.key_drop      = drop;

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, stable-sample count for a key change to be accepted (20 ms at 1 MHz sys_clk); minimum legal value 2.
REQ-002 sys_clk  input  1  system clock, 1 MHz; the single clock of the block.
REQ-003 sys_rst  input  1  asynchronous, active-high reset.
REQ-004 KeyRESTART  input  1  raw restart key, active-high, asynchronous to sys_clk, may bounce.
REQ-005 Keyup  input  1  raw up key, same electrical rules as KeyRESTART.
REQ-006 KeyDown  input  1  raw down key, same rules.
REQ-007 KeyLeft  input  1  raw left key, same rules.
REQ-008 KeyRight  input  1  raw right key, same rules.
REQ-009 restart_pulse, up_pulse, down_pulse, left_pulse, right_pulse  output  1 each  one-cycle press event per key.
REQ-010 key_valid  output  1  one-cycle strobe: an encoded press event is present on key_code.
REQ-011 key_code  output  3  encoded key: 0 none, 1 RESTART, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT.
REQ-012 key_drop  output  1  one-cycle strobe: at least one simultaneous press event lost by the encoder.

Function
REQ-013 Each raw key SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Each key SHALL hold a debounced stable state and a counter wide enough for DEBOUNCE_CYCLES-1.
REQ-015 If synchronized value equals stable state, the counter SHALL clear to 0.
REQ-016 If they differ and count < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 If they differ and count == DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear.
REQ-018 A stable 0->1 transition SHALL produce that key's pulse high for exactly one cycle, registered, the cycle after stable updates.
REQ-019 A stable 1->0 transition SHALL produce no event.
REQ-020 Latency: raw key first sampled high at edge E0 and held SHALL give its pulse high from edge E0+DEBOUNCE_CYCLES+2 for one cycle.
REQ-021 A raw level held fewer than DEBOUNCE_CYCLES consecutive synchronized samples SHALL produce no event; any mismatch-free sample restarts counting.
REQ-022 A key held indefinitely SHALL produce exactly one event.
REQ-023 key_valid SHALL be high in exactly the cycles where any per-key pulse is high, with key_code set in the same cycle.
REQ-024 Simultaneous pulses SHALL encode by priority RESTART > UP > DOWN > LEFT > RIGHT.
REQ-025 key_drop SHALL be high in a cycle where two or more per-key pulses are high; per-key pulses themselves are never suppressed.
REQ-026 key_code SHALL be 0 in every cycle where key_valid is low.
REQ-027 Keys SHALL be fully independent; a held key SHALL NOT block events from other keys.

Reset
REQ-028 sys_rst high SHALL immediately clear synchronizers, stable states, counters and all outputs to 0, regardless of clock.
REQ-029 Reset mid-debounce SHALL discard the partial count; no pulse SHALL be emitted during reset.
REQ-030 A key held high across reset release SHALL be treated as a new press, producing its event per REQ-020 measured from the first post-reset sampling edge.

Structure
REQ-031 A shared package SHALL hold key code constants (KEY_NONE..KEY_RIGHT), the priority order and the DEBOUNCE_CYCLES default.
REQ-032 One sub-module key_debounce_ch (synchronizer, counter, stable state, press pulse) SHALL be instantiated five times; encoder logic stays in the top.

Verification (DEBOUNCE_CYCLES=4, 1 MHz clock)
REQ-033 Keyup high 10 cycles from edge E0 -> up_pulse, key_valid, key_code=2 high one cycle at E0+6; nothing on release.
REQ-034 KeyLeft high 3 cycles then low -> no pulse, key_valid stays 0.
REQ-035 KeyRESTART and Keyup rise same edge, held 10 -> restart_pulse, up_pulse, key_valid, key_drop all high one cycle; key_code=1.
REQ-036 KeyDown 1,0,1,0 per cycle then held 8 -> exactly one event, key_code=3, at first steady edge +6.
REQ-037 KeyRight high 2 cycles, sys_rst pulsed 1 cycle, KeyRight held -> all outputs 0 during reset; one event key_code=5 at first post-reset edge +6.
REQ-038 Keyup held 1000 cycles -> exactly one up_pulse in the whole window.
